// File: rtl/adc_capture_buffer.sv
// adc_capture_buffer
// Snapshots one channel of the RFDC adc_dout stream into block RAM when armed.
// A capture starts either on the next clock or on the next PL SYSREF rising edge.
// The read port is always available and has a two-register pipeline.
module adc_capture_buffer #(
  parameter int NCHAN     = 8,
  parameter int NSAMP     = 8,
  parameter int NBITS     = 12,
  parameter int ADDR_BITS = 10
) (
  input  logic                         aclk,
  input  logic                         aresetn,
  input  logic [NSAMP*NCHAN*NBITS-1:0] adc_dout,
  input  logic                         sysref_i,
  input  logic                         arm_i,
  input  logic                         abort_i,
  input  logic                         sync_mode_i,
  input  logic [$clog2(NCHAN)-1:0]     chan_sel_i,
  input  logic [ADDR_BITS-1:0]         len_i,
  output logic                         busy_o,
  output logic                         done_o,
  input  logic                         rd_en_i,
  input  logic [ADDR_BITS-1:0]         rd_addr_i,
  output logic [NSAMP*NBITS-1:0]       rd_data_o,
  output logic                         rd_valid_o
);

  localparam int WW    = NSAMP * NBITS;
  localparam int CW    = $clog2(NCHAN);
  localparam int DEPTH = 1 << ADDR_BITS;

  typedef enum logic [1:0] {IDLE, WAIT_SYNC, CAPTURE, DONE} state_t;

  state_t               state;
  state_t               next_state;
  logic                 sysref_q;
  logic                 sysref_edge;
  logic [CW-1:0]        chan_q;
  logic [ADDR_BITS-1:0] len_q;
  logic [ADDR_BITS-1:0] waddr;
  logic                 arm_ok;
  logic                 last_write;
  logic                 wr_en;
  logic [WW-1:0]        wr_data;
  logic [WW-1:0]        chan_word [NCHAN];
  logic [WW-1:0]        mem [DEPTH];
  logic [WW-1:0]        ram_q;
  logic                 rd_en_q;

  for (genvar g = 0; g < NCHAN; g++) begin : g_chan
    assign chan_word[g] = adc_dout[g*WW +: WW];
  end

  assign wr_data     = chan_word[chan_q];
  assign sysref_edge = sysref_i & ~sysref_q;
  assign arm_ok      = arm_i && ((state == IDLE) || (state == DONE));
  assign last_write  = (waddr == len_q);
  // Reset must stop writes on the very edge it is sampled, hence the gate.
  assign wr_en       = (state == CAPTURE) && aresetn;

  // State register.
  always_ff @(posedge aclk) begin
    if (!aresetn) state <= IDLE;
    else          state <= next_state;
  end

  // Next-state logic: abort beats completion, arm only from IDLE/DONE.
  always_comb begin
    next_state = state;
    case (state)
      IDLE, DONE: begin
        if (arm_i) next_state = sync_mode_i ? WAIT_SYNC : CAPTURE;
      end
      WAIT_SYNC: begin
        if (abort_i)          next_state = IDLE;
        else if (sysref_edge) next_state = CAPTURE;
      end
      CAPTURE: begin
        if (abort_i)         next_state = IDLE;
        else if (last_write) next_state = DONE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Status outputs decoded from the current state.
  always_comb begin
    busy_o = (state == WAIT_SYNC) || (state == CAPTURE);
    done_o = (state == DONE);
  end

  // SYSREF history, capture parameters latched on arm, and the write pointer.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      sysref_q <= 1'b0;
      chan_q   <= '0;
      len_q    <= '0;
      waddr    <= '0;
    end else begin
      sysref_q <= sysref_i;
      if (arm_ok) begin
        chan_q <= chan_sel_i;
        len_q  <= len_i;
        waddr  <= '0;
      end else if ((state == CAPTURE) && !last_write) begin
        waddr <= waddr + ADDR_BITS'(1);
      end
    end
  end

  // Block RAM: read-first on address collision, contents survive reset.
  always_ff @(posedge aclk) begin
    if (wr_en)   mem[waddr] <= wr_data;
    if (rd_en_i) ram_q      <= mem[rd_addr_i];
  end

  // Read output register stage with its valid pipeline.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      rd_en_q    <= 1'b0;
      rd_valid_o <= 1'b0;
      rd_data_o  <= '0;
    end else begin
      rd_en_q    <= rd_en_i;
      rd_valid_o <= rd_en_q;
      if (rd_en_q) rd_data_o <= ram_q;
    end
  end

endmodule

// File: tb/tb_adc_capture_buffer.sv
// tb_adc_capture_buffer
// Table-driven captures, hand-written abort/reset/collision sequences and
// randomized captures, all checked against a cycle-indexed reference model.
module tb_adc_capture_buffer;

  localparam int NCHAN     = 8;
  localparam int NSAMP     = 8;
  localparam int NBITS     = 12;
  localparam int ADDR_BITS = 10;
  localparam int CW        = $clog2(NCHAN);
  localparam int WW        = NSAMP * NBITS;
  localparam int DW        = NCHAN * WW;
  localparam int DEPTH     = 1 << ADDR_BITS;
  localparam int MAXCYC    = 16384;

  logic                 aclk = 1'b0;
  logic                 aresetn = 1'b0;
  logic [DW-1:0]        adc_dout = '0;
  logic                 sysref_i = 1'b0;
  logic                 arm_i = 1'b0;
  logic                 abort_i = 1'b0;
  logic                 sync_mode_i = 1'b0;
  logic [CW-1:0]        chan_sel_i = '0;
  logic [ADDR_BITS-1:0] len_i = '0;
  logic                 busy_o;
  logic                 done_o;
  logic                 rd_en_i = 1'b0;
  logic [ADDR_BITS-1:0] rd_addr_i = '0;
  logic [WW-1:0]        rd_data_o;
  logic                 rd_valid_o;

  adc_capture_buffer #(
    .NCHAN(NCHAN), .NSAMP(NSAMP), .NBITS(NBITS), .ADDR_BITS(ADDR_BITS)
  ) dut (
    .aclk(aclk), .aresetn(aresetn), .adc_dout(adc_dout), .sysref_i(sysref_i),
    .arm_i(arm_i), .abort_i(abort_i), .sync_mode_i(sync_mode_i),
    .chan_sel_i(chan_sel_i), .len_i(len_i), .busy_o(busy_o), .done_o(done_o),
    .rd_en_i(rd_en_i), .rd_addr_i(rd_addr_i), .rd_data_o(rd_data_o),
    .rd_valid_o(rd_valid_o)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    int chan;
    int len;
    bit sync;
    int delay;
    int pre_hi;
    int exp_busy;
  } vec_t;

  vec_t vecs [6];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit rand_data = 1'b0;
  bit chk_rd    = 1'b0;

  logic [DW-1:0] hist [MAXCYC];
  bit            rd_hist [MAXCYC];
  bit            rdk_hist [MAXCYC];
  logic [WW-1:0] rdv_hist [MAXCYC];

  logic [WW-1:0] model_mem [DEPTH];
  bit            model_known [DEPTH];

  bit cap_on = 1'b0;
  int cap_start = 0;
  int cap_last = -1;
  int cap_chan = 0;

  function automatic logic [WW-1:0] ramp_word(int n, int c);
    logic [WW-1:0] w;
    for (int s = 0; s < NSAMP; s++) w[s*NBITS +: NBITS] = NBITS'((16*n + 8*c + s) % 4096);
    return w;
  endfunction

  // Value the RAM must return for a read issued in cycle j: words the capture
  // wrote in earlier cycles are new, the word written in cycle j itself is old.
  function automatic void expected_read(int j, int a, output bit known, output logic [WW-1:0] val);
    int wc;
    wc = cap_start + a;
    if (cap_on && wc <= cap_last && wc < j) begin
      known = 1'b1;
      val   = hist[wc][cap_chan*WW +: WW];
    end else begin
      known = model_known[a];
      val   = model_mem[a];
    end
  endfunction

  // Fold a finished capture into the model; the abort-cycle write may go either way.
  task automatic commitCapture(input int start, input int last, input int chan, input bit amb);
    for (int c = start; c <= last; c++) begin
      if (amb && c == last) begin
        model_known[c-start] = 1'b0;
      end else begin
        model_mem[c-start]   = hist[c][chan*WW +: WW];
        model_known[c-start] = 1'b1;
      end
    end
    cap_on = 1'b0;
  endtask

  task automatic checkOutput(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic checkRead(input int j);
    checkOutput("rd_valid", WW'(rd_valid_o), WW'(rd_hist[j]));
    if (rd_hist[j] && rdk_hist[j]) checkOutput("rd_data", rd_data_o, rdv_hist[j]);
  endtask

  // One clock cycle: drive ADC data, record history, advance, check reads.
  task automatic applyStimulus();
    bit            k;
    logic [WW-1:0] v;
    if (cyc >= MAXCYC - 1) begin
      n_fail++;
      $display("[TB] FAIL cycle_budget: got %0d cycles expected fewer than %0d", cyc, MAXCYC);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $fatal(1, "[TB] cycle budget exhausted");
    end
    for (int c = 0; c < NCHAN; c++)
      adc_dout[c*WW +: WW] = rand_data ? WW'({$urandom(), $urandom(), $urandom()}) : ramp_word(cyc, c);
    hist[cyc]    = adc_dout;
    rd_hist[cyc] = rd_en_i;
    k = 1'b0;
    v = '0;
    if (rd_en_i) expected_read(cyc, int'(rd_addr_i), k, v);
    rdk_hist[cyc] = k;
    rdv_hist[cyc] = v;
    @(posedge aclk);
    #1;
    cyc++;
    if (chk_rd && cyc >= 2) checkRead(cyc - 2);
  endtask

  task automatic readBack(input int lo, input int hi);
    for (int a = lo; a <= hi; a++) begin
      rd_en_i   = 1'b1;
      rd_addr_i = ADDR_BITS'(a);
      applyStimulus();
    end
    rd_en_i = 1'b0;
    applyStimulus();
    applyStimulus();
  endtask

  // Arm one capture and follow it to DONE, checking busy/done every cycle.
  task automatic runCapture(input vec_t v, input bit rnd_reads);
    int k, start, last, busy_cnt, first_done;
    k     = cyc;
    start = v.sync ? k + v.delay + 1 : k + 1;
    last  = start + v.len;
    chan_sel_i  = CW'(v.chan);
    len_i       = ADDR_BITS'(v.len);
    sync_mode_i = v.sync;
    arm_i       = 1'b1;
    sysref_i    = v.sync && (v.pre_hi > 0);
    if (!v.sync) begin
      cap_on = 1'b1; cap_start = start; cap_last = last; cap_chan = v.chan;
    end
    applyStimulus();
    arm_i = 1'b0;
    busy_cnt = 0;
    first_done = -1;
    for (int t = 1; t <= last + 1 - k; t++) begin
      checkOutput("busy", WW'(busy_o), WW'(k + t <= last));
      checkOutput("done", WW'(done_o), WW'(k + t > last));
      if (busy_o) busy_cnt++;
      if (done_o && first_done < 0) first_done = t;
      if (k + t <= last) begin
        sysref_i = v.sync && (t <= v.pre_hi || t == v.delay);
        if (v.sync && t == v.delay) begin
          cap_on = 1'b1; cap_start = start; cap_last = last; cap_chan = v.chan;
        end
        rd_en_i   = rnd_reads && ($urandom_range(0, 1) == 1);
        rd_addr_i = ADDR_BITS'($urandom_range(0, 63));
        applyStimulus();
      end
    end
    sysref_i = 1'b0;
    rd_en_i  = 1'b0;
    checkOutput("busy_cycles", WW'(busy_cnt), WW'(v.exp_busy));
    checkOutput("done_offset", WW'(first_done), WW'(v.exp_busy + 1));
    commitCapture(start, last, v.chan, 1'b0);
    applyStimulus();
    applyStimulus();
    readBack(0, v.len);
    checkOutput("done_hold", WW'(done_o), WW'(1));
  endtask

  initial begin
    int   k;
    int   seq [8];
    vec_t rv;

    vecs[0] = '{chan: 3, len: 15,   sync: 1'b0, delay: 0,  pre_hi: 0, exp_busy: 16};
    vecs[1] = '{chan: 0, len: 3,    sync: 1'b1, delay: 40, pre_hi: 0, exp_busy: 44};
    vecs[2] = '{chan: 7, len: 0,    sync: 1'b0, delay: 0,  pre_hi: 0, exp_busy: 1};
    vecs[3] = '{chan: 5, len: 7,    sync: 1'b1, delay: 1,  pre_hi: 0, exp_busy: 9};
    vecs[4] = '{chan: 2, len: 4,    sync: 1'b1, delay: 10, pre_hi: 5, exp_busy: 15};
    vecs[5] = '{chan: 1, len: 1023, sync: 1'b0, delay: 0,  pre_hi: 0, exp_busy: 1024};
    seq = '{4, 1, 6, 3, 0, 5, 2, 7};

    $display("[TB] reset");
    aresetn = 1'b0;
    repeat (3) applyStimulus();
    checkOutput("rst_busy", WW'(busy_o), WW'(0));
    checkOutput("rst_done", WW'(done_o), WW'(0));
    checkOutput("rst_rd_valid", WW'(rd_valid_o), WW'(0));
    checkOutput("rst_rd_data", rd_data_o, '0);
    aresetn = 1'b1;
    chk_rd  = 1'b1;
    applyStimulus();

    $display("[TB] table captures");
    for (int i = 0; i < 6; i++) runCapture(vecs[i], 1'b0);

    $display("[TB] abort mid-capture, arm while busy");
    k = cyc;
    chan_sel_i = CW'(6); len_i = ADDR_BITS'(31); sync_mode_i = 1'b0; arm_i = 1'b1;
    cap_on = 1'b1; cap_start = k + 1; cap_last = k + 32; cap_chan = 6;
    applyStimulus();
    arm_i = 1'b0;
    for (int t = 1; t <= 6; t++) begin
      checkOutput("abort_busy", WW'(busy_o), WW'(1));
      arm_i = (t == 3);
      if (t == 3) begin chan_sel_i = '0; len_i = ADDR_BITS'(2); end
      abort_i = (t == 6);
      if (t == 6) cap_last = k + 6;
      applyStimulus();
    end
    abort_i = 1'b0;
    arm_i   = 1'b0;
    checkOutput("abort_idle_busy", WW'(busy_o), WW'(0));
    checkOutput("abort_idle_done", WW'(done_o), WW'(0));
    applyStimulus();
    checkOutput("abort_stays_idle", WW'(busy_o), WW'(0));
    commitCapture(k + 1, k + 6, 6, 1'b1);
    readBack(0, 40);

    $display("[TB] reset mid-capture, re-arm after release");
    k = cyc;
    chan_sel_i = CW'(4); len_i = ADDR_BITS'(20); arm_i = 1'b1;
    cap_on = 1'b1; cap_start = k + 1; cap_last = k + 21; cap_chan = 4;
    applyStimulus();
    arm_i = 1'b0;
    repeat (7) applyStimulus();
    aresetn = 1'b0;
    cap_last = k + 7;
    applyStimulus();
    checkOutput("midrst_busy", WW'(busy_o), WW'(0));
    checkOutput("midrst_done", WW'(done_o), WW'(0));
    checkOutput("midrst_rd_valid", WW'(rd_valid_o), WW'(0));
    checkOutput("midrst_rd_data", rd_data_o, '0);
    commitCapture(k + 1, k + 7, 4, 1'b0);
    aresetn = 1'b1;
    k = cyc;
    len_i = ADDR_BITS'(9); arm_i = 1'b1;
    cap_on = 1'b1; cap_start = k + 1; cap_last = k + 10; cap_chan = 4;
    applyStimulus();
    arm_i = 1'b0;
    for (int t = 1; t <= 10; t++) begin
      checkOutput("rearm_busy", WW'(busy_o), WW'(1));
      applyStimulus();
    end
    checkOutput("rearm_done", WW'(done_o), WW'(1));
    commitCapture(k + 1, k + 10, 4, 1'b0);
    readBack(0, 24);

    $display("[TB] abort in DONE, arm and abort together");
    abort_i = 1'b1;
    applyStimulus();
    checkOutput("done_abort_ignored", WW'(done_o), WW'(1));
    k = cyc;
    chan_sel_i = CW'(0); len_i = ADDR_BITS'(2); arm_i = 1'b1;
    cap_on = 1'b1; cap_start = k + 1; cap_last = k + 3; cap_chan = 0;
    applyStimulus();
    arm_i = 1'b0;
    abort_i = 1'b0;
    for (int t = 1; t <= 3; t++) begin
      checkOutput("armabort_busy", WW'(busy_o), WW'(1));
      applyStimulus();
    end
    checkOutput("armabort_done", WW'(done_o), WW'(1));
    commitCapture(k + 1, k + 3, 0, 1'b0);
    readBack(0, 3);

    $display("[TB] back-to-back reads during capture");
    k = cyc;
    chan_sel_i = CW'(5); len_i = ADDR_BITS'(15); arm_i = 1'b1;
    cap_on = 1'b1; cap_start = k + 1; cap_last = k + 16; cap_chan = 5;
    applyStimulus();
    arm_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      rd_en_i   = 1'b1;
      rd_addr_i = ADDR_BITS'(seq[i]);
      applyStimulus();
    end
    rd_en_i = 1'b0;
    repeat (8) applyStimulus();
    checkOutput("collide_done", WW'(done_o), WW'(1));
    commitCapture(k + 1, k + 16, 5, 1'b0);
    readBack(0, 15);

    $display("[TB] randomized captures");
    rand_data = 1'b1;
    for (int i = 0; i < 10; i++) begin
      rv.chan     = int'($urandom_range(0, NCHAN - 1));
      rv.len      = int'($urandom_range(0, 40));
      rv.sync     = 1'($urandom_range(0, 1));
      rv.delay    = int'($urandom_range(1, 20));
      rv.pre_hi   = (rv.sync && rv.delay >= 3) ? int'($urandom_range(0, rv.delay - 2)) : 0;
      rv.exp_busy = (rv.sync ? rv.delay : 0) + rv.len + 1;
      runCapture(rv, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
